// File: rtl/mem_port.sv
// -----------------------------------------------------------------------------
// mem_port
// Memory-side stage of the datapath. Holds the memory address register (MAR)
// and memory data register (MDR), sequences single accesses to a fixed-latency
// synchronous SRAM, and decodes one memory-mapped I/O word (IO_ADDR). Reads of
// that word return the switch inputs. Writes to it load the hex display
// register.
//
// Ports
//   clk, reset    clock (rising edge); synchronous active-high reset
//   bus_in        datapath bus, source of MAR/MDR loads
//   ld_mar        MAR <= bus_in (always honoured, even during an access)
//   ld_mdr        MDR load. When an access is requested, the load takes
//                 memory/switch data on the data-valid cycle. Otherwise it
//                 takes bus_in.
//   mem_mem_ena   access request, held high by control for the whole access
//   mem_wr_ena    1 = write, 0 = read; only looked at in the first request cycle
//   sw_i          switch inputs (I/O read data)
//   sram_rdata    SRAM read data, valid READ_LAT cycles after a read strobe
//   mdr_o, mar_o  register contents
//   hex_o         hex display register
//   mem_rdy       read data valid / write committed in this cycle
//   sram_ce       SRAM chip enable, one-cycle pulse per SRAM access
//   sram_we       SRAM write enable, meaningful only with sram_ce
//   sram_addr     SRAM address
//   sram_wdata    SRAM write data (MDR)
// -----------------------------------------------------------------------------
module mem_port #(
  parameter int          ADDR_W   = 16,
  parameter int          READ_LAT = 2,
  parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mem_mem_ena,
  input  logic              mem_wr_ena,
  input  logic [15:0]       sw_i,
  input  logic [15:0]       sram_rdata,
  output logic [15:0]       mdr_o,
  output logic [15:0]       mar_o,
  output logic [15:0]       hex_o,
  output logic              mem_rdy,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mar_q, mdr_q, hex_q;
  logic [ADDR_W-1:0] txn_addr;
  logic [2:0]        lat_cnt, lat_cnt_nxt;

  logic              is_io;       // MAR currently selects the I/O word
  logic              start;       // first request cycle (cycle T)
  logic              rd_done;     // read data valid this cycle
  logic [DATA_W-1:0] rd_data;
  logic              hex_load;
  logic              rdy_c, ce_c, we_c;

  assign is_io = (mar_q == IO_ADDR);
  assign start = (state == IDLE) && mem_mem_ena;

  // Next-state and strobe decode
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    rdy_c       = 1'b0;
    ce_c        = 1'b0;
    we_c        = 1'b0;
    rd_done     = 1'b0;
    rd_data     = sram_rdata;
    hex_load    = 1'b0;

    case (state)
      IDLE: begin
        if (mem_mem_ena) begin
          if (is_io) begin
            // I/O completes in the request cycle; no SRAM strobe.
            rdy_c     = 1'b1;
            state_nxt = DONE;
            if (mem_wr_ena) begin
              hex_load = 1'b1;
            end else begin
              rd_done = 1'b1;
              rd_data = sw_i;
            end
          end else begin
            ce_c = 1'b1;
            we_c = mem_wr_ena;
            if (mem_wr_ena) begin
              // The SRAM commits the write on this edge, so it is done now.
              rdy_c     = 1'b1;
              state_nxt = DONE;
            end else begin
              state_nxt   = RD_WAIT;
              lat_cnt_nxt = 3'd1;
            end
          end
        end
      end

      RD_WAIT: begin
        if (!mem_mem_ena) begin
          // Control gave up on the access: abort without data.
          state_nxt = IDLE;
        end else if (lat_cnt == 3'(READ_LAT)) begin
          rdy_c     = 1'b1;
          rd_done   = 1'b1;
          rd_data   = sram_rdata;
          state_nxt = DONE;
        end else begin
          lat_cnt_nxt = lat_cnt + 3'd1;
        end
      end

      DONE: begin
        // Wait for the request to drop so one request gives one access.
        if (!mem_mem_ena) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A reset cycle must not emit strobes or commit data.
    if (reset) begin
      rdy_c    = 1'b0;
      ce_c     = 1'b0;
      we_c     = 1'b0;
      rd_done  = 1'b0;
      hex_load = 1'b0;
    end
  end

  // State, transaction address and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lat_cnt  <= 3'd0;
      txn_addr <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      if (start) begin
        txn_addr <= mar_q[ADDR_W-1:0];
      end
    end
  end

  // MAR / MDR / hex registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mar_q <= '0;
      mdr_q <= '0;
      hex_q <= '0;
    end else begin
      if (ld_mar) begin
        mar_q <= bus_in;
      end
      if (ld_mdr) begin
        if (rd_done) begin
          mdr_q <= rd_data;
        end else if (!mem_mem_ena) begin
          mdr_q <= bus_in;
        end
        // With a request outstanding and no data yet, the load is deferred.
      end
      if (hex_load) begin
        hex_q <= mdr_q;
      end
    end
  end

  // In the request cycle the address comes straight from MAR. After that the
  // latched copy is used, so a mid-access ld_mar cannot redirect the access.
  assign sram_addr  = (state == IDLE) ? mar_q[ADDR_W-1:0] : txn_addr;
  assign sram_wdata = mdr_q;
  assign sram_ce    = ce_c;
  assign sram_we    = we_c;
  assign mem_rdy    = rdy_c;
  assign mdr_o      = mdr_q;
  assign mar_o      = mar_q;
  assign hex_o      = hex_q;

endmodule

// File: tb/tb_mem_port.sv
module tb_mem_port;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mem_mem_ena, mem_wr_ena;
  logic [15:0] sw_i, sram_rdata;
  logic [15:0] mdr_o, mar_o, hex_o;
  logic        mem_rdy, sram_ce, sram_we;
  logic [15:0] sram_addr, sram_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port #(.ADDR_W(16), .READ_LAT(LAT), .IO_ADDR(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena), .sw_i(sw_i),
    .sram_rdata(sram_rdata), .mdr_o(mdr_o), .mar_o(mar_o), .hex_o(hex_o),
    .mem_rdy(mem_rdy), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata)
  );

  // Environment SRAM: writes commit on the strobe edge. Read data appears LAT
  // cycles after a read strobe and is unknown otherwise.
  logic [15:0] sram [0:65535];
  logic [15:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (sram_ce && sram_we) sram[sram_addr] <= sram_wdata;
    rd_p1 <= (sram_ce && !sram_we) ? sram[sram_addr] : 16'hxxxx;
    rd_p2 <= rd_p1;
  end
  assign sram_rdata = rd_p2;

  // Reference model: architectural state only
  logic [15:0] ref_mem [0:65535];
  logic [15:0] mar_m, mdr_m, hex_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_mar = 0; ld_mdr = 0; mem_mem_ena = 0; mem_wr_ena = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_mar"}, mar_o, mar_m);
    chk({tag, "_mdr"}, mdr_o, mdr_m);
    chk({tag, "_hex"}, hex_o, hex_m);
  endtask

  task automatic load_mar(input logic [15:0] v);
    ld_mar = 1; bus_in = v;
    next_cycle();
    ld_mar = 0; bus_in = $urandom;
    mar_m = v;
    chk("ld_mar", mar_o, mar_m);
  endtask

  task automatic load_mdr(input logic [15:0] v);
    ld_mdr = 1; mem_mem_ena = 0; bus_in = v;
    next_cycle();
    ld_mdr = 0; bus_in = $urandom;
    mdr_m = v;
    chk("ld_mdr", mdr_o, mdr_m);
  endtask

  // One request window of len cycles, then one idle cycle
  task automatic access(input bit wr, input int len, input bit ld,
                        input bit mid_mar, input logic [15:0] new_mar);
    logic [15:0] a;
    logic [15:0] rd;
    bit io;
    bit completes;
    a  = mar_m;
    io = (a == 16'hFFFF);
    rd = io ? sw_i : ref_mem[a];
    completes = wr || io || (len > LAT);
    for (int c = 0; c < len; c++) begin
      mem_mem_ena = 1;
      mem_wr_ena  = (c == 0) ? wr : ~wr;
      ld_mdr      = ld;
      ld_mar      = mid_mar && (c == 1);
      bus_in      = ld_mar ? new_mar : 16'($urandom);
      @(negedge clk);
      chk("sram_ce", sram_ce, (c == 0) && !io);
      if (c == 0 && !io) chk("sram_we", sram_we, wr);
      chk("mem_rdy", mem_rdy,
          ((c == 0) && (wr || io)) || ((c == LAT) && !wr && !io));
      if (!io) chk("sram_addr", sram_addr, a);
      if (c == 0 && wr && !io) chk("sram_wdata", sram_wdata, mdr_m);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("idle_rdy", mem_rdy, 1'b0);
    chk("idle_ce", sram_ce, 1'b0);
    if (mid_mar && len >= 2) mar_m = new_mar;
    if (wr) begin
      if (io) hex_m = mdr_m;
      else ref_mem[a] = mdr_m;
    end else if (ld && completes) begin
      mdr_m = rd;
    end
    next_cycle();
    check_regs("after_access");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[3] = 16'h1234; ref_mem[3] = 16'h1234;
    mar_m = 0; mdr_m = 0; hex_m = 0;
    bus_in = 16'h5A5A; sw_i = 0;
    idle_inputs();

    // Reset state
    reset = 1; mem_mem_ena = 1;
    @(negedge clk);
    chk("rst_rdy", mem_rdy, 1'b0);
    chk("rst_ce", sram_ce, 1'b0);
    chk("rst_we", sram_we, 1'b0);
    next_cycle();
    next_cycle();
    reset = 0; mem_mem_ena = 0;
    check_regs("reset");

    // Test 1: SRAM read of 3 with a 3-cycle window
    load_mar(16'h0003);
    access(0, 3, 1, 0, 0);
    chk("t1_mdr", mdr_o, 16'h1234);

    // Test 2: write BEEF to 5, read back
    load_mar(16'h0005);
    load_mdr(16'hBEEF);
    access(1, 1, 0, 0, 0);
    load_mdr(16'h0000);
    access(0, 3, 1, 0, 0);
    chk("t2_readback", mdr_o, 16'hBEEF);

    // Test 3: I/O read and write
    load_mar(16'hFFFF);
    sw_i = 16'h00A5;
    access(0, 1, 1, 0, 0);
    chk("t3_sw", mdr_o, 16'h00A5);
    load_mdr(16'h0042);
    access(1, 1, 0, 0, 0);
    chk("t3_hex", hex_o, 16'h0042);

    // Test 4: read aborted at T+1, MDR retains prior value
    load_mar(16'h0003);
    load_mdr(16'h6666);
    access(0, 1, 1, 0, 0);
    chk("t4_mdr", mdr_o, 16'h6666);
    // Aborted exactly at the data cycle
    access(0, 2, 1, 0, 0);
    chk("t4b_mdr", mdr_o, 16'h6666);

    // Test 5: long hold, ld_mar mid-read
    load_mar(16'h0005);
    access(0, 6, 1, 1, 16'h0009);
    chk("t5_mar", mar_o, 16'h0009);
    chk("t5_mdr", mdr_o, 16'hBEEF);

    // Test 6: reset at T+1 of a read
    load_mar(16'h0003);
    mem_mem_ena = 1; mem_wr_ena = 0; ld_mdr = 1;
    next_cycle();
    reset = 1;
    next_cycle();
    reset = 0; idle_inputs();
    mar_m = 0; mdr_m = 0; hex_m = 0;
    check_regs("t6_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_rdy", mem_rdy, 1'b0);
      chk("t6_ce", sram_ce, 1'b0);
      next_cycle();
    end
    load_mdr(16'h7777);

    // Randomized operations over a small address pool
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [15:0] pool_addr;
      op = $urandom_range(0, 4);
      pool_addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      sw_i = 16'($urandom);
      case (op)
        0: load_mar(pool_addr);
        1: load_mdr(16'($urandom));
        2: access(1, $urandom_range(1, 3), $urandom_range(0, 1), 0, 0);
        default: access(0, $urandom_range(1, 6), $urandom_range(0, 1),
                        $urandom_range(0, 1), pool_addr);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
